// File: rtl/coax_link_pkg.sv
// coax_link_pkg: shared constants, FSM states and CRC-8 step for the coax link
package coax_link_pkg;
    localparam logic [7:0] SYNC_WORD = 8'hD5;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC, SYNC_CHK} state_t;
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic d);
        return {c[6:0], 1'b0} ^ ((c[7] ^ d) ? CRC8_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 LFSR shared by framer and deframer
module crc8_serial
    import coax_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    // One LFSR step per enable; clear wins over enable
    always_ff @(posedge clk)
        if (!rst_n || clr) crc <= CRC8_INIT;
        else if (en) crc <= crc8_step(crc, din);
endmodule

// File: rtl/coax_frame_deframer.sv
// coax_frame_deframer: sync hunt, payload/CRC-8 check, frame lock and error count
module coax_frame_deframer
    import coax_link_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int LOCK_FRAMES = 4,
    parameter int MISS_MAX    = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk_link,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 cdr_locked,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 crc_err,
    output logic                 frame_locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(MISS_MAX + 1);
    state_t                state, next_st;
    logic [7:0]            sr, sr_nx, crc;
    logic [DATA_W-1:0]     payload;
    logic [5:0]            bit_cnt;
    logic [GW-1:0]         good_cnt, good_nx;
    logic [BW-1:0]         bad_cnt, bad_nx;
    logic [ERR_CNT_W-1:0]  err_nx;
    logic                  sync_ok, pay_last, byte_last, good_evt, bad_evt, drop, lock_nx;
    logic                  crc_clr, crc_en;

    crc8_serial u_crc (
        .clk   (clk_link),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (bit_in),
        .crc   (crc)
    );

    // Per-bit compares, frame verdicts and counter next values
    always_comb begin
        sr_nx     = {sr[6:0], bit_in};
        sync_ok   = sr_nx == SYNC_WORD;
        pay_last  = bit_cnt == 6'(DATA_W - 1);
        byte_last = bit_cnt == 6'd7;
        good_evt  = byte_last && state == CRC && sr_nx == crc;
        bad_evt   = byte_last && (state == CRC ? sr_nx != crc : state == SYNC_CHK && !sync_ok);
        bad_nx    = bad_cnt + 1'b1;
        drop      = bad_evt && bad_nx == BW'(MISS_MAX);
        good_nx   = good_cnt == GW'(LOCK_FRAMES) ? good_cnt : good_cnt + 1'b1;
        err_nx    = &err_cnt ? err_cnt : err_cnt + 1'b1;
        lock_nx   = good_evt ? frame_locked || good_nx == GW'(LOCK_FRAMES) : frame_locked && !drop;
        next_st   = state == SYNC_CHK ? (drop ? HUNT : PAYLOAD) : (lock_nx ? SYNC_CHK : HUNT);
        crc_clr   = !cdr_locked || (bit_valid && (state == HUNT || state == SYNC_CHK));
        crc_en    = bit_valid && state == PAYLOAD;
    end

    // Frame FSM with lock/error tracking; CDR loss drops any frame in progress
    always_ff @(posedge clk_link) begin
        data_valid <= 1'b0;
        crc_err    <= 1'b0;
        if (!rst_n || !cdr_locked) begin
            state        <= HUNT;
            sr           <= '0;
            payload      <= '0;
            bit_cnt      <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            frame_locked <= 1'b0;
            if (!rst_n) begin
                data_out <= '0;
                err_cnt  <= '0;
            end
        end else if (bit_valid) begin
            case (state)
                HUNT: begin
                    sr    <= sync_ok ? '0 : sr_nx;
                    state <= sync_ok ? PAYLOAD : HUNT;
                end
                PAYLOAD: begin
                    payload <= {payload[DATA_W-2:0], bit_in};
                    bit_cnt <= pay_last ? '0 : bit_cnt + 1'b1;
                    state   <= pay_last ? CRC : PAYLOAD;
                end
                default: begin
                    sr      <= byte_last ? '0 : sr_nx;
                    bit_cnt <= byte_last ? '0 : bit_cnt + 1'b1;
                    if (good_evt) begin
                        data_out   <= payload;
                        data_valid <= 1'b1;
                        good_cnt   <= good_nx;
                        bad_cnt    <= '0;
                    end
                    if (bad_evt) begin
                        crc_err  <= state == CRC;
                        err_cnt  <= err_nx;
                        good_cnt <= '0;
                        bad_cnt  <= drop ? '0 : bad_nx;
                    end
                    if (byte_last) begin
                        state        <= next_st;
                        frame_locked <= lock_nx;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/coax_frame_deframer.md
Name: coax_frame_deframer

Overview:
Consumes the recovered bit stream from the 4x-oversampling CDR (bit, bit-valid strobe, CDR lock) in the clk_link domain.
- Hunts for the frame sync word and assembles fixed-length payload words.
- Checks the per-frame CRC-8 and delivers good payloads with a 1-cycle valid strobe.
- Tracks frame-level lock and a saturating error count for link monitoring and register readout.

Parameters:
DATA_W, 24, payload bits per frame (MSB first); multiple of 8, 8..32
LOCK_FRAMES, 4, consecutive CRC-good frames required to assert frame_locked
MISS_MAX, 3, consecutive bad frames (sync mismatch or CRC error) that drop frame lock
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk_link  in  1  200MHz link clock
rst_n  in  1  synchronous, active-low reset
bit_in  in  1  recovered data bit from CDR
bit_valid  in  1  1-cycle strobe; bit_in is valid this cycle
cdr_locked  in  1  CDR lock status
data_out  out  DATA_W  last CRC-good payload; holds until the next good frame
data_valid  out  1  1-cycle pulse; data_out is updated in the same cycle
crc_err  out  1  1-cycle pulse on a CRC mismatch
frame_locked  out  1  frame alignment established
err_cnt  out  ERR_CNT_W  saturating count of CRC errors plus sync misses

Behaviour:
- Frame format: SYNC (8 bits, 0xD5) | payload (DATA_W bits) | CRC (8 bits). All fields MSB first.
- CRC-8: poly 0x07, init 0x00, no reflection, no final XOR. Computed serially over the payload bits only.
- Bits are consumed only on cycles with bit_valid=1. All state holds otherwise.
- Reset: data_out=0, data_valid=0, crc_err=0, frame_locked=0, err_cnt=0, state=HUNT, all counters and shift registers cleared.
- States:
  - HUNT: an 8-bit sliding register shifts in each bit. When the register equals 0xD5 on a bit_valid cycle, go to PAYLOAD; clear the CRC register and bit counter.
  - PAYLOAD: shift the bit into the payload register and CRC LFSR. After DATA_W bits, go to CRC.
  - CRC: shift 8 bits into the received-CRC register. On the 8th bit, evaluate in the same cycle using registered compare logic. Outputs appear on the next clock edge (latency: 1 cycle after the bit_valid of the last CRC bit).
    - CRC match: data_out <= payload, data_valid=1, good_cnt++ (saturating at LOCK_FRAMES), bad_cnt=0.
    - CRC mismatch: crc_err=1, err_cnt++, good_cnt=0, bad_cnt++.
    - Next state: SYNC_CHK if frame_locked (after this update) is 1, else HUNT with the sliding register cleared.
  - SYNC_CHK: collect exactly 8 bits.
    - If equal to 0xD5: go to PAYLOAD.
    - Otherwise: err_cnt++, bad_cnt++, good_cnt=0. Go to PAYLOAD anyway (flywheel) unless bad_cnt reaches MISS_MAX.
- frame_locked:
  - Sets in the same cycle data_valid pulses for the good frame that makes good_cnt == LOCK_FRAMES.
  - Clears when bad_cnt reaches MISS_MAX. The state then goes to HUNT and bad_cnt and good_cnt clear.
- CRC error plus sync miss on consecutive frames both count toward bad_cnt.
- cdr_locked=0, checked every cycle and taking priority over everything:
  - state=HUNT; frame_locked=0; good_cnt=bad_cnt=0; all shift registers and counters cleared.
  - A frame in progress is dropped: no data_valid, no crc_err, no err_cnt increment.
  - data_out and err_cnt hold their values.
- err_cnt saturates at all-ones; it never wraps.
- data_valid and crc_err are never asserted in the same cycle.

Decomposition:
- Package coax_link_pkg: SYNC_WORD=8'hD5, CRC8_POLY=8'h07, CRC8_INIT=8'h00, state enum {HUNT, PAYLOAD, CRC, SYNC_CHK}.
- Sub-module crc8_serial:
  - Inputs: clk, rst_n, clr, en, din.
  - Output: crc[7:0].
  - One LFSR step per en; clr has priority over en.
  - Reused by the transmit-side framer.

Test Plan:
- Reset, then cdr_locked=1 with the bit stream 0xD5, 0x000000, 0x00 -> data_out=0x000000 and data_valid pulses once, 1 cycle after the last bit_valid. frame_locked=0, err_cnt=0.
- Random idle bits, then 4 back-to-back frames with payload 0x000001 and CRC 0x07 -> 4 data_valid pulses; frame_locked rises with the 4th pulse; 5th frame is checked in SYNC_CHK.
- While locked, send a frame with CRC 0x06 instead of 0x07 -> crc_err pulse, no data_valid, data_out holds 0x000001, err_cnt=1, frame_locked stays 1.
- While locked, corrupt the sync of 3 consecutive frames (0xD4) -> err_cnt increments by 3; frame_locked drops on the 3rd miss; state=HUNT; the next clean frame yields data_valid.
- Drop cdr_locked mid-payload, then restore it and send a clean frame -> no pulse for the partial frame; frame_locked=0 immediately; the next clean frame is delivered.
- Preload err_cnt to 0xFFFF via repeated CRC errors (or a forced value) and inject one more error -> err_cnt stays 0xFFFF.
